// File: rtl/ps_intr_ctrl.sv
// ps_intr_ctrl
// Interrupt responder for the program sequencer. The external interrupt line
// is synchronised and every rising edge becomes a pending request. The request
// is taken at an instruction boundary, or while the core sits in IDLE. Taking
// it redirects the PC to VECTOR_ADDR and pushes the return address onto a
// small hardware stack. An RTI pops that stack to supply the return PC.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-low reset
//   interrupt         external asynchronous request (rising edge = request)
//   ps_pc             address of the next instruction that would execute
//   ps_instr_boundary current instruction completes this cycle
//   ps_idle           core halted in IDLE
//   ps_rti            RTI completing this cycle
//   ps_irpten         global interrupt enable
//   int_take          one-cycle pulse: load int_vector into the PC
//   int_vector        constant ISR entry address
//   int_ret_valid     one-cycle pulse: load int_ret_addr into the PC
//   int_ret_addr      last popped return address
//   int_pending       request latched and not yet taken
//   int_active        return stack non-empty (inside an ISR)
//   int_wake          pulse alongside int_take when taken from IDLE
//   int_err           sticky: [0] merged request, [1] RTI with empty stack

module ps_intr_ctrl #(
   parameter int                  PMA_SIZE    = 16,
   parameter logic [PMA_SIZE-1:0] VECTOR_ADDR = 16'h0004,
   parameter int                  STACK_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                interrupt,
   input  logic [PMA_SIZE-1:0] ps_pc,
   input  logic                ps_instr_boundary,
   input  logic                ps_idle,
   input  logic                ps_rti,
   input  logic                ps_irpten,
   output logic                int_take,
   output logic [PMA_SIZE-1:0] int_vector,
   output logic                int_ret_valid,
   output logic [PMA_SIZE-1:0] int_ret_addr,
   output logic                int_pending,
   output logic                int_active,
   output logic                int_wake,
   output logic [1:0]          int_err
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_PEND = 2'd1,
      ST_TAKE = 2'd2
   } state_t;

   // The stack pointer is 3 bits wide, so the storage is sized for the full
   // pointer range. Only the first STACK_DEPTH entries are ever written.
   localparam logic [2:0] DEPTH = 3'(STACK_DEPTH);

   state_t              state_q;
   state_t              state_d;
   logic                sync1;
   logic                sync2;
   logic                sync2_d;
   logic                int_edge;
   logic                pending_q;
   logic [2:0]          sp;
   logic [2:0]          sp_dec;
   logic [PMA_SIZE-1:0] stack [0:7];
   logic                stack_full;
   logic                eligible;
   logic                do_pop;
   logic                rti_underflow;
   logic                ret_valid_q;
   logic                wake_q;
   logic [1:0]          err_q;
   logic [PMA_SIZE-1:0] ret_addr_q;

   assign int_edge      = sync2 & ~sync2_d;
   assign stack_full    = (sp == DEPTH);
   assign sp_dec        = sp - 3'd1;
   assign do_pop        = ps_rti & (sp != 3'd0);
   assign rti_underflow = ps_rti & (sp == 3'd0);

   // Comparing state_q against ST_TAKE is the same as ~int_take.
   // It keeps the next-state process free of a feedback path through its
   // own output. The ~ps_rti term lets a simultaneous RTI win.
   assign eligible = pending_q & ps_irpten & (ps_instr_boundary | ps_idle)
                     & ~stack_full & ~ps_rti & (state_q != ST_TAKE);

   assign int_vector    = VECTOR_ADDR;
   assign int_ret_valid = ret_valid_q;
   assign int_ret_addr  = ret_addr_q;
   assign int_pending   = pending_q;
   assign int_active    = (sp != 3'd0);
   assign int_wake      = wake_q;
   assign int_err       = err_q;

   // Three-flop synchroniser. The third flop gives the previous synchronised
   // level, which is used for rising-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync2_d <= 1'b0;
      end else begin
         sync1   <= interrupt;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_WAIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and the take pulse. TAKE always lasts exactly one cycle.
   // It falls back to PEND when a new request was latched during the take.
   always_comb begin
      state_d  = state_q;
      int_take = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (int_edge) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (eligible) begin
               state_d = ST_TAKE;
            end
         end
         ST_TAKE: begin
            int_take = 1'b1;
            if (pending_q | int_edge) begin
               state_d = ST_PEND;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // Pending latch and merge error.
   // An edge that lands on the same clock as the take is a fresh request, not
   // a merge, so pending re-arms without flagging int_err[0].
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q <= 1'b0;
         err_q     <= 2'b00;
      end else begin
         if (eligible) begin
            pending_q <= int_edge;
         end else if (int_edge) begin
            pending_q <= 1'b1;
            if (pending_q) begin
               err_q[0] <= 1'b1;
            end
         end
         if (rti_underflow) begin
            err_q[1] <= 1'b1;
         end
      end
   end

   // Return-address stack.
   // A push and a pop can never coincide, because eligible excludes ps_rti.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp          <= 3'd0;
         ret_addr_q  <= '0;
         ret_valid_q <= 1'b0;
         wake_q      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            stack[i] <= '0;
         end
      end else begin
         ret_valid_q <= do_pop;
         wake_q      <= eligible & ps_idle;
         if (eligible) begin
            stack[sp] <= ps_pc;
            sp        <= sp + 3'd1;
         end else if (do_pop) begin
            sp         <= sp_dec;
            ret_addr_q <= stack[sp_dec];
         end
      end
   end

endmodule

// File: tb/tb_ps_intr_ctrl.sv
// tb_ps_intr_ctrl
// Self-checking bench for ps_intr_ctrl.
// Expected takes (with their wake flag) and expected return addresses are
// queued when stimulus is driven. A negedge monitor pops the queues whenever
// the DUT pulses int_take or int_ret_valid. Directed checks cover reset,
// latency, masking, nesting, collision, underflow and asynchronous reset.

module tb_ps_intr_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        interrupt;
   logic [15:0] ps_pc;
   logic        ps_instr_boundary;
   logic        ps_idle;
   logic        ps_rti;
   logic        ps_irpten;
   logic        int_take;
   logic [15:0] int_vector;
   logic        int_ret_valid;
   logic [15:0] int_ret_addr;
   logic        int_pending;
   logic        int_active;
   logic        int_wake;
   logic [1:0]  int_err;

   int          totalCount = 0;
   int          badCount   = 0;
   bit          takeQ[$];
   logic [15:0] retQ[$];
   bit          expWake;
   logic [15:0] expRet;

   ps_intr_ctrl dut (
      .clk               (clk),
      .reset             (reset),
      .interrupt         (interrupt),
      .ps_pc             (ps_pc),
      .ps_instr_boundary (ps_instr_boundary),
      .ps_idle           (ps_idle),
      .ps_rti            (ps_rti),
      .ps_irpten         (ps_irpten),
      .int_take          (int_take),
      .int_vector        (int_vector),
      .int_ret_valid     (int_ret_valid),
      .int_ret_addr      (int_ret_addr),
      .int_pending       (int_pending),
      .int_active        (int_active),
      .int_wake          (int_wake),
      .int_err           (int_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [15:0] pc, input logic boundary,
                                input logic idle, input logic irpten);
      ps_pc             = pc;
      ps_instr_boundary = boundary;
      ps_idle           = idle;
      ps_irpten         = irpten;
   endtask

   task automatic pulseInterrupt();
      interrupt = 1'b1;
      tick();
      tick();
      interrupt = 1'b0;
   endtask

   task automatic waitForTake(input string tag, input int limit);
      int  n     = 0;
      bit  found = 1'b0;
      while (!found && n < limit) begin
         tick();
         n++;
         if (int_take) found = 1'b1;
      end
      checkOutput(tag, 32'(found), 32'd1);
   endtask

   task automatic doRti();
      ps_rti = 1'b1;
      tick();
      ps_rti = 1'b0;
   endtask

   // Scoreboard monitor. It samples on the falling edge, away from the DUT
   // update edge.
   always @(negedge clk) begin
      if (int_take) begin
         if (takeQ.size() == 0) begin
            checkOutput("unexpected_take", 32'(int_take), 32'd0);
         end else begin
            expWake = takeQ.pop_front();
            checkOutput("take_vector", 32'(int_vector), 32'h0004);
            checkOutput("take_wake", 32'(int_wake), 32'(expWake));
         end
      end else if (int_wake) begin
         checkOutput("stray_wake", 32'(int_wake), 32'd0);
      end
      if (int_ret_valid) begin
         if (retQ.size() == 0) begin
            checkOutput("unexpected_ret", 32'(int_ret_valid), 32'd0);
         end else begin
            expRet = retQ.pop_front();
            checkOutput("ret_addr", 32'(int_ret_addr), 32'(expRet));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      interrupt = 1'b0;
      ps_rti    = 1'b0;
      applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("rst_take", 32'(int_take), 32'd0);
      checkOutput("rst_ret_valid", 32'(int_ret_valid), 32'd0);
      checkOutput("rst_pending", 32'(int_pending), 32'd0);
      checkOutput("rst_active", 32'(int_active), 32'd0);
      checkOutput("rst_wake", 32'(int_wake), 32'd0);
      checkOutput("rst_err", 32'(int_err), 32'd0);
      checkOutput("rst_ret_addr", 32'(int_ret_addr), 32'd0);
      checkOutput("rst_vector", 32'(int_vector), 32'h0004);
      reset = 1'b1;
      tick();

      $display("[TB] basic take and return");
      applyStimulus(16'h0020, 1'b1, 1'b0, 1'b1);
      takeQ.push_back(1'b0);
      interrupt = 1'b1;
      tick();
      tick();
      checkOutput("t1_pending_early", 32'(int_pending), 32'd0);
      tick();
      checkOutput("t1_pending", 32'(int_pending), 32'd1);
      checkOutput("t1_take_early", 32'(int_take), 32'd0);
      tick();
      checkOutput("t1_take_latency", 32'(int_take), 32'd1);
      checkOutput("t1_active", 32'(int_active), 32'd1);
      checkOutput("t1_pending_clr", 32'(int_pending), 32'd0);
      interrupt = 1'b0;
      tick();
      checkOutput("t1_take_once", 32'(int_take), 32'd0);
      retQ.push_back(16'h0020);
      doRti();
      checkOutput("t1_ret_valid", 32'(int_ret_valid), 32'd1);
      checkOutput("t1_ret_addr", 32'(int_ret_addr), 32'h0020);
      checkOutput("t1_inactive", 32'(int_active), 32'd0);
      tick();
      checkOutput("t1_ret_once", 32'(int_ret_valid), 32'd0);

      $display("[TB] wake from idle");
      applyStimulus(16'h0031, 1'b0, 1'b1, 1'b1);
      takeQ.push_back(1'b1);
      pulseInterrupt();
      waitForTake("t2_take_timeout", 6);
      checkOutput("t2_wake", 32'(int_wake), 32'd1);
      applyStimulus(16'h0031, 1'b0, 1'b0, 1'b1);
      retQ.push_back(16'h0031);
      doRti();
      checkOutput("t2_ret_addr", 32'(int_ret_addr), 32'h0031);
      tick();

      $display("[TB] masked requests merge");
      applyStimulus(16'h0040, 1'b1, 1'b0, 1'b0);
      pulseInterrupt();
      tick();
      tick();
      pulseInterrupt();
      repeat (4) tick();
      checkOutput("t3_pending", 32'(int_pending), 32'd1);
      checkOutput("t3_err_merge", 32'(int_err), 32'd1);
      takeQ.push_back(1'b0);
      ps_irpten = 1'b1;
      waitForTake("t3_take_timeout", 4);
      repeat (3) tick();
      checkOutput("t3_pending_clr", 32'(int_pending), 32'd0);
      retQ.push_back(16'h0040);
      doRti();
      tick();

      $display("[TB] nesting and full stack");
      applyStimulus(16'h0000, 1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         ps_pc = 16'(k);
         takeQ.push_back(1'b0);
         pulseInterrupt();
         waitForTake("t4_take_timeout", 6);
      end
      ps_pc = 16'h0005;
      pulseInterrupt();
      repeat (6) tick();
      checkOutput("t4_full_pending", 32'(int_pending), 32'd1);
      checkOutput("t4_full_active", 32'(int_active), 32'd1);
      retQ.push_back(16'h0004);
      takeQ.push_back(1'b0);
      doRti();
      checkOutput("t4_ret_valid", 32'(int_ret_valid), 32'd1);
      checkOutput("t4_ret_addr", 32'(int_ret_addr), 32'h0004);
      checkOutput("t4_no_take_yet", 32'(int_take), 32'd0);
      tick();
      checkOutput("t4_take_after_pop", 32'(int_take), 32'd1);
      retQ.push_back(16'h0005);
      retQ.push_back(16'h0003);
      retQ.push_back(16'h0002);
      retQ.push_back(16'h0001);
      ps_rti = 1'b1;
      repeat (4) tick();
      ps_rti = 1'b0;
      tick();
      checkOutput("t4_unwound", 32'(int_active), 32'd0);
      checkOutput("t4_last_ret", 32'(int_ret_addr), 32'h0001);

      reset = 1'b0;
      tick();
      checkOutput("mid_rst_err", 32'(int_err), 32'd0);
      reset = 1'b1;
      tick();

      $display("[TB] rti collision and underflow");
      applyStimulus(16'h0050, 1'b1, 1'b0, 1'b1);
      takeQ.push_back(1'b0);
      pulseInterrupt();
      waitForTake("t5_take_timeout", 6);
      ps_irpten = 1'b0;
      ps_pc     = 16'h0060;
      pulseInterrupt();
      repeat (4) tick();
      checkOutput("t5_pending", 32'(int_pending), 32'd1);
      retQ.push_back(16'h0050);
      takeQ.push_back(1'b0);
      ps_irpten = 1'b1;
      doRti();
      checkOutput("t5_pop_first", 32'(int_ret_valid), 32'd1);
      checkOutput("t5_pop_addr", 32'(int_ret_addr), 32'h0050);
      checkOutput("t5_take_held", 32'(int_take), 32'd0);
      checkOutput("t5_still_pending", 32'(int_pending), 32'd1);
      tick();
      checkOutput("t5_take_late", 32'(int_take), 32'd1);
      retQ.push_back(16'h0060);
      doRti();
      tick();
      doRti();
      checkOutput("t5_underflow_valid", 32'(int_ret_valid), 32'd0);
      checkOutput("t5_underflow_err", 32'(int_err), 32'd2);
      tick();

      $display("[TB] async reset inside isr");
      applyStimulus(16'h0070, 1'b1, 1'b0, 1'b1);
      takeQ.push_back(1'b0);
      pulseInterrupt();
      waitForTake("t6_take1_timeout", 6);
      ps_pc = 16'h0071;
      takeQ.push_back(1'b0);
      pulseInterrupt();
      waitForTake("t6_take2_timeout", 6);
      tick();
      checkOutput("t6_active", 32'(int_active), 32'd1);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("t6_rst_active", 32'(int_active), 32'd0);
      checkOutput("t6_rst_pending", 32'(int_pending), 32'd0);
      checkOutput("t6_rst_take", 32'(int_take), 32'd0);
      checkOutput("t6_rst_ret_valid", 32'(int_ret_valid), 32'd0);
      checkOutput("t6_rst_wake", 32'(int_wake), 32'd0);
      checkOutput("t6_rst_err", 32'(int_err), 32'd0);
      checkOutput("t6_rst_ret_addr", 32'(int_ret_addr), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      doRti();
      checkOutput("t6_lost_ret_valid", 32'(int_ret_valid), 32'd0);
      checkOutput("t6_lost_err", 32'(int_err), 32'd2);
      tick();
      tick();

      checkOutput("take_queue_left", 32'(takeQ.size()), 32'd0);
      checkOutput("ret_queue_left", 32'(retQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule

// File: doc/ps_intr_ctrl.md
# ps_intr_ctrl

Interrupt responder for the program sequencer. It synchronises the external `interrupt` line and latches each rising edge as a pending request. At an instruction boundary, or while the core sits in IDLE, it redirects the PC to a fixed vector and pushes the return address onto a small hardware stack. On RTI it pops that stack to supply the return PC.

## Interface
- PMA_SIZE, 16, program-memory address width (PC width)
- VECTOR_ADDR, 16'h0004, interrupt service routine entry address
- STACK_DEPTH, 4, return-address stack entries (nesting depth); pointer width 3 bits, supports 1..7
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clock clk
- interrupt  in  1  external request, asynchronous level; a rising edge is one request
- ps_pc  in  PMA_SIZE  address of the next instruction that would execute
- ps_instr_boundary  in  1  current instruction completes this cycle; PC may be redirected
- ps_idle  in  1  core halted in IDLE instruction
- ps_rti  in  1  RTI decoded and completing this cycle
- ps_irpten  in  1  global interrupt enable
- int_take  out  1  one-cycle pulse: sequencer loads int_vector into PC
- int_vector  out  PMA_SIZE  constant VECTOR_ADDR
- int_ret_valid  out  1  one-cycle pulse: sequencer loads int_ret_addr into PC
- int_ret_addr  out  PMA_SIZE  popped return address, held until next pop
- int_pending  out  1  request latched, not yet taken
- int_active  out  1  stack non-empty (inside an ISR)
- int_wake  out  1  pulse: exit IDLE (asserted together with int_take when taken from IDLE)
- int_err  out  2  sticky: [0] edge merged into an already-pending request, [1] RTI with empty stack

## Operation
- Synchroniser: sync1 <= interrupt, sync2 <= sync1, sync2_d <= sync2. Edge = sync2 & ~sync2_d.
- Pending latch: set on edge. Cleared on take. An edge while pending stays set and sets int_err[0].
- Eligible = int_pending & ps_irpten & (ps_instr_boundary | ps_idle) & ~stack_full & ~ps_rti & ~int_take.
- Take, on the clock edge where Eligible holds:
  - push ps_pc: stack[sp] <= ps_pc, sp <= sp+1
  - clear pending; register int_take=1 for the next cycle
  - int_wake=1 if ps_idle was sampled high
- RTI, on the clock edge where ps_rti holds:
  - sp>0: sp <= sp-1; int_ret_addr <= stack[sp-1]; int_ret_valid=1 for the next cycle
  - sp==0: no pop, int_ret_valid stays 0, int_err[1] <= 1
- State machine:
  - WAIT: no pending, go to PEND on edge
  - PEND: go to TAKE when Eligible
  - TAKE: one cycle, int_take high; go to PEND if a new edge arrived meanwhile, else WAIT
  - int_ret_valid is independent of the state machine.
- Nesting: a take inside an ISR is allowed whenever ps_irpten=1. When the stack is full (sp==STACK_DEPTH), the request stays pending until an RTI frees an entry. No overflow is possible.
- ps_rti and Eligible in the same cycle: RTI wins, the request stays pending and is re-evaluated from the next cycle.
- A take with ps_irpten low never occurs; pending is held indefinitely.
- int_active = (sp != 0).

## Timing
- Reset (async, low): sync flops, sp, pending, int_take, int_ret_valid, int_wake, int_err = 0; int_ret_addr = 0; stack contents = 0; state WAIT. int_vector is always VECTOR_ADDR.
- Interrupt rising and sampled at edge N: sync2 at N+1, int_pending=1 after edge N+2.
- Take latency:
  - from pending visible: int_take is high in the cycle after the first edge sampling Eligible
  - minimum interrupt-to-int_take is 3 clock edges
- int_take, int_wake and int_ret_valid each last exactly one cycle; they never assert twice back-to-back for one event.
- Reset deasserted mid-ISR: stack is lost, and a subsequent RTI flags int_err[1].
- Interrupt pulse shorter than one clock may be missed; a request requires at least one sampled high.

## Test plan
- Basic take: ps_irpten=1, ps_pc=16'h0020, pulse interrupt, boundary held high -> int_take exactly 3 edges after the interrupt sample, int_vector=16'h0004, int_active=1; then ps_rti -> int_ret_valid with int_ret_addr=16'h0020, int_active=0.
- IDLE wake: ps_idle=1, boundary=0, ps_pc=16'h0031, interrupt -> int_take and int_wake in the same cycle, return address 16'h0031.
- Masking/merge: ps_irpten=0, two interrupt edges -> int_pending=1, int_err[0]=1, no int_take; raise ps_irpten with boundary -> a single int_take.
- Nesting and full stack: 5 requests, PCs 1..5, no RTI, depth 4 -> 4 takes, 5th stays pending; one RTI returns 4, next cycle take pushes 5; subsequent RTIs return 5,3,2,1.
- Collision and underflow: Eligible and ps_rti in the same cycle -> pop first, int_take one cycle later; RTI at sp=0 -> no int_ret_valid, int_err=2'b10.
- Async reset mid-ISR at sp=2 -> all outputs 0 immediately, int_ret_addr=0, int_active=0.
